// File: rtl/countdown_timer.sv
// Loads a unit count on start and counts it down at one unit per P clocks (ms or us), pulsing done on expiry.
// All outputs registered; busy follows start by one edge, pause freezes the countdown one edge per high cycle.
module countdown_timer #(
  parameter int FREQ_IN          = 12000000,
  parameter int LIMIT_LOAD_TIMER = 1000,
  parameter int SELECT_UNITS     = 1,
  parameter int SIZE_LOAD_TIMER  = $clog2(LIMIT_LOAD_TIMER + 1)
) (
  input  logic                       clk,
  input  logic                       resetTimer,
  input  logic                       start,
  input  logic                       pause,
  input  logic [SIZE_LOAD_TIMER-1:0] loadValue,
  output logic [SIZE_LOAD_TIMER-1:0] remaining,
  output logic                       busy,
  output logic                       paused,
  output logic                       done,
  output logic                       expired
);

  localparam int P  = FREQ_IN / ((SELECT_UNITS != 0) ? 1000000 : 1000);
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  localparam logic [PW-1:0]              PRE_LAST = PW'(P - 1);
  localparam logic [PW-1:0]              PRE_ONE  = PW'(1);
  localparam logic [SIZE_LOAD_TIMER-1:0] LIMIT    = SIZE_LOAD_TIMER'(LIMIT_LOAD_TIMER);
  localparam logic [SIZE_LOAD_TIMER-1:0] UNIT_ONE = SIZE_LOAD_TIMER'(1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t                       state, nextState;
  logic [PW-1:0]                prescaler, nextPrescaler;
  logic [SIZE_LOAD_TIMER-1:0]   nextRemaining;
  logic [SIZE_LOAD_TIMER-1:0]   loadSat;
  logic                         nextDone;

  // Oversized loads saturate at the limit rather than wrapping.
  assign loadSat = (loadValue > LIMIT) ? LIMIT : loadValue;

  always_comb begin
    nextState     = state;
    nextPrescaler = prescaler;
    nextRemaining = remaining;
    nextDone      = 1'b0;
    if (start) begin
      // Start beats pause and discards any in-flight countdown silently.
      nextPrescaler = '0;
      nextRemaining = loadSat;
      if (loadSat == '0) begin
        nextState = DONE;
        nextDone  = 1'b1;
      end else begin
        nextState = pause ? HOLD : RUN;
      end
    end else begin
      case (state)
        RUN, HOLD: begin
          if (pause) begin
            nextState = HOLD;
          end else begin
            nextState = RUN;
            if (prescaler == PRE_LAST) begin
              nextPrescaler = '0;
              if (remaining <= UNIT_ONE) begin
                nextRemaining = '0;
                nextState     = DONE;
                nextDone      = 1'b1;
              end else begin
                nextRemaining = remaining - UNIT_ONE;
              end
            end else begin
              nextPrescaler = prescaler + PRE_ONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge resetTimer) begin
    if (resetTimer) begin
      state     <= IDLE;
      prescaler <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      paused    <= 1'b0;
      done      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= nextState;
      prescaler <= nextPrescaler;
      remaining <= nextRemaining;
      busy      <= (nextState == RUN) || (nextState == HOLD);
      paused    <= (nextState == HOLD);
      done      <= nextDone;
      expired   <= (nextState == DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table, hand-written corner sequences, then random traffic vs a cycle-budget model.
module tb_countdown_timer;

  localparam int P   = 12;
  localparam int LIM = 10;
  localparam int SZ  = 4;

  logic          clk = 1'b0;
  logic          resetTimer;
  logic          start;
  logic          pause;
  logic [SZ-1:0] loadValue;
  logic [SZ-1:0] remaining;
  logic          busy;
  logic          paused;
  logic          done;
  logic          expired;

  int checks = 0;
  int errors = 0;

  countdown_timer #(
    .FREQ_IN(12000000),
    .LIMIT_LOAD_TIMER(LIM),
    .SELECT_UNITS(1)
  ) dut (
    .clk(clk),
    .resetTimer(resetTimer),
    .start(start),
    .pause(pause),
    .loadValue(loadValue),
    .remaining(remaining),
    .busy(busy),
    .paused(paused),
    .done(done),
    .expired(expired)
  );

  always #5 clk = ~clk;

  // Model: an active countdown is a budget of un-paused clock edges (L*P);
  // units left are that budget divided by P, rounded up.
  int mMode;
  int mCl;
  bit mPaused;
  bit mDone;

  function automatic void modelReset();
    mMode   = 0;
    mCl     = 0;
    mPaused = 1'b0;
    mDone   = 1'b0;
  endfunction

  function automatic void modelEdge(input bit s, input bit p, input int lv);
    int l;
    l = (lv > LIM) ? LIM : lv;
    if (s) begin
      mCl = l * P;
      if (l == 0) begin
        mMode = 2; mDone = 1'b1; mPaused = 1'b0;
      end else begin
        mMode = 1; mDone = 1'b0; mPaused = p;
      end
    end else if (mMode == 1) begin
      mDone   = 1'b0;
      mPaused = p;
      if (!p) begin
        mCl--;
        if (mCl == 0) begin
          mMode = 2; mDone = 1'b1;
        end
      end
    end else begin
      mDone = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkModel(input string tag);
    chk({tag, " remaining"}, 32'(remaining), (mMode == 1) ? (mCl + P - 1) / P : 0);
    chk({tag, " busy"},      32'(busy),      32'(mMode == 1));
    chk({tag, " paused"},    32'(paused),    32'(mPaused));
    chk({tag, " done"},      32'(done),      32'(mDone));
    chk({tag, " expired"},   32'(expired),   32'(mMode == 2));
  endtask

  // Drives one edge; returns at active edge + 1.
  task automatic step(input bit s, input bit p, input logic [SZ-1:0] lv);
    start = s; pause = p; loadValue = lv;
    @(posedge clk);
    modelEdge(s, p, int'(lv));
    #1;
  endtask

  task automatic countdown(input string name, input int lv, input int expL,
                           input int pFrom, input int pLen, input int expDoneEdge);
    int firstDone;
    int nDone;
    int prevRem;
    logic [SZ-1:0] lvb;
    bit p;
    firstDone = -1;
    nDone = 0;
    lvb = SZ'(lv);
    step(1'b1, 1'b0, lvb);
    if (done) begin nDone++; firstDone = 0; end
    chk({name, " loaded"}, 32'(remaining), expL);
    for (int e = 1; e <= expDoneEdge + 3; e++) begin
      p = (pLen > 0) && (e >= pFrom) && (e < pFrom + pLen);
      prevRem = int'(remaining);
      step(1'b0, p, '0);
      if (done) begin
        nDone++;
        if (firstDone < 0) firstDone = e;
      end
      if (p) begin
        chk({name, " paused flag"}, 32'(paused), 1);
        chk({name, " held remaining"}, 32'(remaining), prevRem);
      end
      if (pLen == 0 && (e % P) == 0 && e <= expL * P)
        chk({name, " tick remaining"}, 32'(remaining), expL - e / P);
      if (expL == 0) chk({name, " busy never"}, 32'(busy), 0);
    end
    chk({name, " done edge"}, firstDone, expDoneEdge);
    chk({name, " done count"}, nDone, 1);
    chk({name, " busy end"}, 32'(busy), 0);
    chk({name, " expired end"}, 32'(expired), 1);
  endtask

  typedef struct {
    bit s; bit p; int lv;
    int rem; bit bsy; bit psd; bit dn; bit exd;
  } vec_t;

  vec_t vt[11];

  initial begin
    int firstDone;
    int nDone;
    bit anyBad;
    bit pr;
    bit s;

    vt[0]  = '{0, 1, 7,  0,  0, 0, 0, 0};
    vt[1]  = '{1, 0, 0,  0,  0, 0, 1, 1};
    vt[2]  = '{0, 1, 0,  0,  0, 0, 0, 1};
    vt[3]  = '{1, 1, 2,  2,  1, 1, 0, 0};
    vt[4]  = '{0, 1, 0,  2,  1, 1, 0, 0};
    vt[5]  = '{0, 0, 0,  2,  1, 0, 0, 0};
    vt[6]  = '{1, 0, 15, 10, 1, 0, 0, 0};
    vt[7]  = '{1, 1, 0,  0,  0, 0, 1, 1};
    vt[8]  = '{0, 0, 0,  0,  0, 0, 0, 1};
    vt[9]  = '{1, 0, 1,  1,  1, 0, 0, 0};
    vt[10] = '{0, 1, 0,  1,  1, 1, 0, 0};

    resetTimer = 1'b1; start = 1'b0; pause = 1'b0; loadValue = '0;
    modelReset();
    #22;
    chk("reset remaining", 32'(remaining), 0);
    chk("reset busy",      32'(busy),      0);
    chk("reset paused",    32'(paused),    0);
    chk("reset done",      32'(done),      0);
    chk("reset expired",   32'(expired),   0);
    resetTimer = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(vt[i].s, vt[i].p, SZ'(vt[i].lv));
      chk($sformatf("vec%0d remaining", i), 32'(remaining), vt[i].rem);
      chk($sformatf("vec%0d busy", i),      32'(busy),      32'(vt[i].bsy));
      chk($sformatf("vec%0d paused", i),    32'(paused),    32'(vt[i].psd));
      chk($sformatf("vec%0d done", i),      32'(done),      32'(vt[i].dn));
      chk($sformatf("vec%0d expired", i),   32'(expired),   32'(vt[i].exd));
    end

    countdown("plain3",   3,  3,  0, 0, 36);
    countdown("pause3",   3,  3,  7, 5, 41);
    countdown("zero",     0,  0,  0, 0, 0);
    countdown("two",      2,  2,  0, 0, 24);
    countdown("saturate", 15, 10, 0, 0, 120);

    // Restart mid-countdown: only the second countdown may report done.
    firstDone = -1; nDone = 0;
    step(1'b1, 1'b0, SZ'(5));
    for (int e = 1; e <= 45; e++) begin
      if (e == 30) step(1'b1, 1'b0, SZ'(1));
      else         step(1'b0, 1'b0, '0);
      if (e == 30) chk("restart loaded", 32'(remaining), 1);
      if (done) begin
        nDone++;
        if (firstDone < 0) firstDone = e;
      end
    end
    chk("restart done edge", firstDone, 42);
    chk("restart done count", nDone, 1);

    // Restart on the same edge as the final tick.
    step(1'b1, 1'b0, SZ'(1));
    for (int e = 1; e < P; e++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, SZ'(2));
    chk("tick restart done",      32'(done),      0);
    chk("tick restart remaining", 32'(remaining), 2);
    chk("tick restart busy",      32'(busy),      1);

    // Asynchronous reset between edges.
    step(1'b1, 1'b0, SZ'(5));
    for (int e = 1; e <= 20; e++) step(1'b0, 1'b0, '0);
    chk("pre-reset remaining", 32'(remaining), 4);
    #3 resetTimer = 1'b1;
    modelReset();
    #1;
    chk("async reset remaining", 32'(remaining), 0);
    chk("async reset busy",      32'(busy),      0);
    chk("async reset paused",    32'(paused),    0);
    chk("async reset done",      32'(done),      0);
    chk("async reset expired",   32'(expired),   0);
    #2 resetTimer = 1'b0;
    anyBad = 1'b0;
    for (int e = 0; e < 80; e++) begin
      step(1'b0, 1'b0, '0);
      if (done || busy || expired) anyBad = 1'b1;
    end
    chk("post-reset quiet", 32'(anyBad), 0);

    // Random traffic against the model.
    pr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      s = ($urandom_range(59) == 0);
      if ($urandom_range(7) == 0) pr = ~pr;
      step(s, pr, SZ'($urandom_range(15)));
      checkModel("rnd");
      if ($urandom_range(699) == 0) begin
        #3 resetTimer = 1'b1;
        modelReset();
        #1 checkModel("rnd reset");
        #2 resetTimer = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
